blob_box_serializer: RTL

// Reader side of the blob analyzer's box table. At each end-of-frame it

---
 rtl/blob_box_serializer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/blob_box_serializer.sv
// Box table serializer: at each end-of-frame it snapshots the packed box bus
// and valid mask, then streams A5, frame_id, count, 9 bytes per valid box
// and a wrap-sum checksum over a valid/ready byte stream.
module blob_box_serializer #(
  parameter int MAX_OBJ_NUM = 15,
  parameter int H_BITS      = 10,
  parameter int V_BITS      = 9,
  parameter int BOX_BS      = 2 * (H_BITS + V_BITS)
) (
  input  logic                          app_clk,
  input  logic                          app_rst_n,
  input  logic                          frame_done,
  input  logic [MAX_OBJ_NUM*BOX_BS-1:0] boxes_in,
  input  logic [MAX_OBJ_NUM-1:0]        box_mask,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_last,
  output logic                          busy,
  output logic [7:0]                    drop_cnt
);

  localparam int SW = $clog2(MAX_OBJ_NUM + 1);

  typedef enum logic [2:0] {IDLE, HDR, SCAN, BOX, CSUM} state_t;

  state_t                          state;
  logic [MAX_OBJ_NUM*BOX_BS-1:0]   shadow_boxes;
  logic [MAX_OBJ_NUM-1:0]          shadow_mask;
  logic [7:0]                      frame_id;
  logic [7:0]                      pkt_id;
  logic [SW-1:0]                   slot;
  logic [3:0]                      byte_idx;
  logic [7:0]                      csum;

  logic [BOX_BS-1:0]               box_sel;
  logic                            slot_valid;
  logic [63:0]                     box_vec;
  logic [7:0]                      next_box_byte;
  logic [7:0]                      obj_count;

  wire accept = tx_valid && tx_ready;

  // Select the shadow slot under scan and lay out its coordinates as 4 big-endian 16-bit words
  always_comb begin
    box_sel    = '0;
    slot_valid = 1'b0;
    for (int unsigned i = 0; i < MAX_OBJ_NUM; i++) begin
      if (slot == SW'(i)) begin
        box_sel    = shadow_boxes[i*BOX_BS +: BOX_BS];
        slot_valid = shadow_mask[i];
      end
    end
    box_vec = {{(16-V_BITS){1'b0}}, box_sel[BOX_BS-1 -: V_BITS],
               {(16-V_BITS){1'b0}}, box_sel[2*H_BITS+V_BITS-1 -: V_BITS],
               {(16-H_BITS){1'b0}}, box_sel[2*H_BITS-1 -: H_BITS],
               {(16-H_BITS){1'b0}}, box_sel[H_BITS-1:0]};
    // byte_idx 0 is the slot byte; coordinate byte k (1..8) follows byte k-1
    next_box_byte = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (byte_idx == 4'(i)) next_box_byte = box_vec[(7-i)*8 +: 8];
    end
  end

  // Number of valid boxes in the snapshot
  always_comb begin
    obj_count = '0;
    for (int unsigned i = 0; i < MAX_OBJ_NUM; i++) begin
      obj_count = obj_count + 8'(shadow_mask[i]);
    end
  end

  // Packet FSM with registered stream outputs, frame id and drop counter
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      state        <= IDLE;
      shadow_boxes <= '0;
      shadow_mask  <= '0;
      frame_id     <= '0;
      pkt_id       <= '0;
      slot         <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      tx_last      <= 1'b0;
      busy         <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (frame_done) frame_id <= frame_id + 8'd1;
      if (frame_done && busy && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (frame_done) begin
            shadow_boxes <= boxes_in;
            shadow_mask  <= box_mask;
            pkt_id       <= frame_id;
            busy         <= 1'b1;
            tx_valid     <= 1'b1;
            tx_data      <= 8'hA5;
            tx_last      <= 1'b0;
            byte_idx     <= '0;
            csum         <= '0;
            state        <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            case (byte_idx)
              4'd0: begin
                tx_data  <= pkt_id;
                byte_idx <= 4'd1;
              end
              4'd1: begin
                csum     <= csum + tx_data;
                tx_data  <= obj_count;
                byte_idx <= 4'd2;
              end
              default: begin
                csum     <= csum + tx_data;
                tx_valid <= 1'b0;
                slot     <= '0;
                state    <= SCAN;
              end
            endcase
          end
        end
        SCAN: begin
          if (slot == SW'(MAX_OBJ_NUM)) begin
            tx_valid <= 1'b1;
            tx_data  <= csum;
            tx_last  <= 1'b1;
            state    <= CSUM;
          end else if (slot_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'(slot);
            byte_idx <= '0;
            state    <= BOX;
          end else begin
            slot <= slot + 1'b1;
          end
        end
        BOX: begin
          if (accept) begin
            csum <= csum + tx_data;
            if (byte_idx == 4'd8) begin
              tx_valid <= 1'b0;
              slot     <= slot + 1'b1;
              state    <= SCAN;
            end else begin
              tx_data  <= next_box_byte;
              byte_idx <= byte_idx + 4'd1;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
